fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the cpu core. It owns the program counter and reads 16-bit instructions from a synchronous instruction memory. For each instruction it drives the core's instruction-register load and start strobes, then waits for the core's wait flag before fetching the next word. It also accepts PC overrides for branches and stops on a HALT opcode.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_reg.sv | 25 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the core it feeds:
// fetch FSM state encoding and instruction opcode field location.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_REQ  = 3'd1,
    S_IF_WAIT = 3'd2,
    S_LOAD    = 3'd3,
    S_START   = 3'd4,
    S_SETTLE  = 3'd5,
    S_EXEC    = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [2:0] HALT_OPCODE = 3'b111;
  localparam int         OPC_MSB     = 15;
  localparam int         OPC_LSB     = 13;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset value, wrap-around increment and
// parallel load, with load taking priority over increment.
module pc_reg #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_inc,
  input  logic                i_load,
  input  logic [PC_WIDTH-1:0] i_load_val,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_val;
    else if (i_inc)  r_pc <= r_pc + 1'b1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one word per instruction, hands it to the
// core with load/start strobes and waits for the core to go idle again.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [2:0]          HALT_OPCODE = 3'b111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    mem_addr,
  output logic                   mem_rd,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_ready,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] cpu_in,
  output logic                   cpu_load,
  output logic                   cpu_s,
  input  logic                   cpu_w,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);
  import cpu_pkg::*;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_mem_rd, r_cpu_load, r_cpu_s, r_halted;
  logic                   w_mem_rd_nxt, w_cpu_load_nxt, w_cpu_s_nxt, w_halted_nxt;
  logic [INSTR_WIDTH-1:0] r_cpu_in;
  logic [PC_WIDTH-1:0]    w_pc;
  logic                   w_fetch_done, w_branch, w_is_halt;

  assign w_fetch_done = (r_state == S_IF_WAIT) && mem_ready;
  assign w_branch     = pc_load && ((r_state == S_SETTLE) || (r_state == S_EXEC));
  assign w_is_halt    = (r_cpu_in[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_inc      (w_fetch_done),
    .i_load     (w_branch),
    .i_load_val (pc_in),
    .o_pc       (w_pc)
  );

  // State and strobe registers; strobes are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_rd   <= 1'b0;
      r_cpu_load <= 1'b0;
      r_cpu_s    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_cpu_load <= w_cpu_load_nxt;
      r_cpu_s    <= w_cpu_s_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (run) w_state_nxt = S_IF_REQ;
      S_IF_REQ:  w_state_nxt = S_IF_WAIT;
      S_IF_WAIT: if (mem_ready) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_START;
      S_START:   w_state_nxt = S_SETTLE;
      // The core drops w only one cycle after s, so w is not trusted here.
      S_SETTLE:  w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (cpu_w) begin
          if (w_is_halt) w_state_nxt = S_HALT;
          else if (run)  w_state_nxt = S_IF_REQ;
          else           w_state_nxt = S_IDLE;
        end
      end
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_rd_nxt   = (w_state_nxt == S_IF_REQ);
    w_cpu_load_nxt = (w_state_nxt == S_LOAD);
    w_cpu_s_nxt    = (w_state_nxt == S_START);
    w_halted_nxt   = (w_state_nxt == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset)             r_cpu_in <= '0;
    else if (w_fetch_done) r_cpu_in <= mem_rdata;
  end

  assign mem_addr = w_pc;
  assign pc       = w_pc;
  assign mem_rd   = r_mem_rd;
  assign cpu_in   = r_cpu_in;
  assign cpu_load = r_cpu_load;
  assign cpu_s    = r_cpu_s;
  assign halted   = r_halted;

endmodule
